// File: rtl/uart_fifo_link.sv
// ============================================================================
//  Module   : uart_fifo_link (+ uart_fifo_link_fifo)
//  Brief    : 16x-oversampled UART endpoint with FWFT RX/TX FIFOs and error flags
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_link_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);
    localparam int c_DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(c_DEPTH));
    assign o_empty   = (r_count == '0);
    // A push into a full FIFO is dropped even when a pop happens in the same cycle
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end
endmodule

module uart_fifo_link #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 19200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int FIFO_AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_stream,
    output logic                 tx_stream,
    input  logic                 rx_pop,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic [FIFO_AW:0]     rx_count,
    output logic                 rx_overrun,
    input  logic                 err_clear,
    input  logic                 tx_push,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_full,
    output logic [FIFO_AW:0]     tx_count,
    output logic                 tx_idle
);
    localparam int c_DIV_RAW = (CLK_FREQ + 8 * BAUD_RATE) / (16 * BAUD_RATE);
    localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
    localparam int c_BCW     = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_BW      = $clog2(DATA_BITS);
    localparam logic [c_BCW-1:0] c_BAUD_LAST = c_BCW'(c_DIV - 1);
    localparam logic [c_BW-1:0]  c_BIT_LAST  = c_BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_PAR   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    function automatic logic f_par(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [c_BCW-1:0] r_baud;
    logic             w_tick;
    logic [1:0]       r_rx_sync;
    logic             w_rx_line;

    assign w_tick    = (r_baud == c_BAUD_LAST);
    assign w_rx_line = r_rx_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud    <= '0;
            r_rx_sync <= 2'b11;
        end else begin
            r_baud    <= w_tick ? '0 : r_baud + c_BCW'(1);
            r_rx_sync <= {r_rx_sync[0], rx_stream};
        end
    end

    // ---------------- receiver ----------------
    state_t                r_rx_state, w_rx_state_nx;
    logic [3:0]            r_rx_tcnt, w_rx_tcnt_nx;
    logic [c_BW-1:0]       r_rx_bcnt, w_rx_bcnt_nx;
    logic [DATA_BITS-1:0]  r_rx_shift, w_rx_shift_nx;
    logic                  r_rx_pbit, w_rx_pbit_nx;
    logic                  w_rx_push;
    logic                  w_rx_perr;
    logic                  w_rx_full;
    logic                  w_rx_empty;
    logic                  r_overrun;
    logic [DATA_BITS+1:0]  w_rx_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_tcnt  <= '0;
            r_rx_bcnt  <= '0;
            r_rx_shift <= '0;
            r_rx_pbit  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_tcnt  <= w_rx_tcnt_nx;
            r_rx_bcnt  <= w_rx_bcnt_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_pbit  <= w_rx_pbit_nx;
        end
    end

    always_comb begin
        w_rx_perr = 1'b0;
        if (PARITY == 1)      w_rx_perr = ~(^r_rx_shift ^ r_rx_pbit);
        else if (PARITY == 2) w_rx_perr = ^r_rx_shift ^ r_rx_pbit;
    end

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_tcnt_nx  = r_rx_tcnt;
        w_rx_bcnt_nx  = r_rx_bcnt;
        w_rx_shift_nx = r_rx_shift;
        w_rx_pbit_nx  = r_rx_pbit;
        w_rx_push     = 1'b0;
        if (w_tick) begin
            w_rx_tcnt_nx = r_rx_tcnt + 4'd1;
            case (r_rx_state)
                S_IDLE: begin
                    w_rx_tcnt_nx = '0;
                    if (!w_rx_line) w_rx_state_nx = S_START;
                end
                S_START: begin
                    // Tick 7 lands mid start bit; later samples follow every 16 ticks
                    if (r_rx_tcnt == 4'd7) begin
                        w_rx_tcnt_nx  = '0;
                        w_rx_bcnt_nx  = '0;
                        w_rx_state_nx = w_rx_line ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_rx_tcnt == 4'd15) begin
                        w_rx_shift_nx = {w_rx_line, r_rx_shift[DATA_BITS-1:1]};
                        w_rx_bcnt_nx  = r_rx_bcnt + 1'b1;
                        if (r_rx_bcnt == c_BIT_LAST)
                            w_rx_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (r_rx_tcnt == 4'd15) begin
                        w_rx_pbit_nx  = w_rx_line;
                        w_rx_state_nx = S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_rx_tcnt == 4'd15) begin
                        w_rx_push     = 1'b1;
                        w_rx_state_nx = S_IDLE;
                    end
                end
                default: w_rx_state_nx = S_IDLE;
            endcase
        end
    end

    uart_fifo_link_fifo #(.WIDTH(DATA_BITS + 2), .AW(FIFO_AW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  ({w_rx_perr, ~w_rx_line, r_rx_shift}),
        .i_pop   (rx_pop),
        .o_data  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full),
        .o_count (rx_count)
    );

    always_ff @(posedge clk) begin
        if (rst)                         r_overrun <= 1'b0;
        else if (w_rx_push && w_rx_full) r_overrun <= 1'b1;
        else if (err_clear)              r_overrun <= 1'b0;
    end

    assign rx_valid      = !w_rx_empty;
    assign rx_data       = w_rx_head[DATA_BITS-1:0];
    assign rx_frame_err  = w_rx_head[DATA_BITS];
    assign rx_parity_err = w_rx_head[DATA_BITS+1];
    assign rx_overrun    = r_overrun;

    // ---------------- transmitter ----------------
    state_t                r_tx_state, w_tx_state_nx;
    logic [3:0]            r_tx_tcnt, w_tx_tcnt_nx;
    logic [c_BW-1:0]       r_tx_bcnt, w_tx_bcnt_nx;
    logic [DATA_BITS-1:0]  r_tx_shift, w_tx_shift_nx;
    logic                  r_tx_par, w_tx_par_nx;
    logic                  w_tx_pop;
    logic                  w_tx_empty;
    logic [DATA_BITS-1:0]  w_tx_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_tcnt  <= w_tx_tcnt_nx;
            r_tx_bcnt  <= w_tx_bcnt_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_par   <= w_tx_par_nx;
        end
    end

    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_tcnt_nx  = r_tx_tcnt;
        w_tx_bcnt_nx  = r_tx_bcnt;
        w_tx_shift_nx = r_tx_shift;
        w_tx_par_nx   = r_tx_par;
        w_tx_pop      = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_shift_nx = w_tx_head;
                    w_tx_par_nx   = f_par(w_tx_head);
                    w_tx_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_tick) begin
                    w_tx_tcnt_nx  = '0;
                    w_tx_state_nx = S_START;
                end
            end
            default: begin
                if (w_tick) begin
                    w_tx_tcnt_nx = r_tx_tcnt + 4'd1;
                    if (r_tx_tcnt == 4'd15) begin
                        case (r_tx_state)
                            S_START: begin
                                w_tx_bcnt_nx  = '0;
                                w_tx_state_nx = S_DATA;
                            end
                            S_DATA: begin
                                w_tx_shift_nx = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                                w_tx_bcnt_nx  = r_tx_bcnt + 1'b1;
                                if (r_tx_bcnt == c_BIT_LAST)
                                    w_tx_state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                            end
                            S_PAR: w_tx_state_nx = S_STOP;
                            default: begin
                                // End of stop bit: chain straight into the next frame if queued
                                if (!w_tx_empty) begin
                                    w_tx_pop      = 1'b1;
                                    w_tx_shift_nx = w_tx_head;
                                    w_tx_par_nx   = f_par(w_tx_head);
                                    w_tx_state_nx = S_START;
                                end else begin
                                    w_tx_state_nx = S_IDLE;
                                end
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (r_tx_state)
            S_START: tx_stream = 1'b0;
            S_DATA:  tx_stream = r_tx_shift[0];
            S_PAR:   tx_stream = r_tx_par;
            default: tx_stream = 1'b1;
        endcase
    end

    uart_fifo_link_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_push),
        .i_data  (tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (tx_full),
        .o_count (tx_count)
    );

    assign tx_idle = (r_tx_state == S_IDLE) && w_tx_empty;
endmodule

`default_nettype wire
